// File: rtl/mod_note_tracker.sv
// Held-note tracker: keeps an ordered stack of held MIDI notes and drives the
// synth with the newest held note. Note-on/off messages are resolved by a
// one-entry-per-cycle search followed by a single parallel update cycle.
module mod_note_tracker #(
    parameter int DEPTH   = 8,
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [23:0]                  i_msg,
    input  logic                         i_msg_valid,
    output logic                         o_msg_ready,
    output logic [6:0]                   o_note,
    output logic [6:0]                   o_velocity,
    output logic                         o_gate,
    output logic                         o_retrigger,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_UPDATE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [6:0]    stk_note [DEPTH];
    logic [6:0]    stk_vel  [DEPTH];
    logic [6:0]    note_nx  [DEPTH];
    logic [6:0]    vel_nx   [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;

    logic [6:0]    lat_note;
    logic [6:0]    lat_vel;
    logic          lat_on;
    logic [IW-1:0] scan;
    logic [IW-1:0] idx;
    logic          found;
    logic [IW-1:0] rm_idx;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] top_idx;

    logic [3:0]    msg_kind;
    logic [3:0]    msg_chan;
    logic [6:0]    msg_d1;
    logic [6:0]    msg_d2;
    logic          chan_ok;
    logic          msg_on;
    logic          msg_off;
    logic          msg_anf;
    logic          xfer;
    logic          scan_hit;
    logic          scan_last;
    logic          count_zero;
    logic          unused_bits;

    // Message decode; bit 7 of each data byte carries no meaning and is dropped
    assign msg_kind    = i_msg[23:20];
    assign msg_chan    = i_msg[19:16];
    assign msg_d1      = i_msg[14:8];
    assign msg_d2      = i_msg[6:0];
    assign unused_bits = ^{i_msg[15], i_msg[7]};
    assign chan_ok     = OMNI || (msg_chan == 4'(CHANNEL));
    assign msg_on      = chan_ok && (msg_kind == 4'h9) && (msg_d2 != 7'd0);
    assign msg_off     = chan_ok && ((msg_kind == 4'h8) ||
                                     ((msg_kind == 4'h9) && (msg_d2 == 7'd0)));
    assign msg_anf     = chan_ok && (msg_kind == 4'hB) && (msg_d1 == 7'd123);
    assign xfer        = i_msg_valid && o_msg_ready;

    assign scan_hit    = (stk_note[scan] == lat_note);
    assign scan_last   = (CW'(scan) == (count - CW'(1)));
    assign count_zero  = (count == '0);

    assign o_count     = count;
    assign o_gate      = !count_zero;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake: only IDLE accepts; note messages start a search
    always_comb begin
        state_nx    = state;
        o_msg_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                o_msg_ready = 1'b1;
                if (i_msg_valid && (msg_on || msg_off)) begin
                    state_nx = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (count_zero || scan_hit || scan_last) begin
                    state_nx = ST_UPDATE;
                end
            end
            ST_UPDATE: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Latch the accepted note message and walk the scan index during SEARCH
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_note <= '0;
            lat_vel  <= '0;
            lat_on   <= 1'b0;
            scan     <= '0;
            idx      <= '0;
            found    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer && (msg_on || msg_off)) begin
                        lat_note <= msg_d1;
                        lat_vel  <= msg_d2;
                        lat_on   <= msg_on;
                        scan     <= '0;
                        found    <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (!count_zero && scan_hit) begin
                        found <= 1'b1;
                        idx   <= scan;
                    end else begin
                        scan <= scan + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next stack image: either push at the top, or remove one slot (the matched
    // entry, or entry 0 when full) by shifting down and optionally rewrite the top
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            note_nx[IW'(i)] = stk_note[IW'(i)];
            vel_nx[IW'(i)]  = stk_vel[IW'(i)];
        end
        count_nx = count;
        rm_idx   = found ? idx : '0;
        last_idx = IW'(count - CW'(1));
        if (lat_on && !found && (count < CW'(DEPTH))) begin
            note_nx[IW'(count)] = lat_note;
            vel_nx[IW'(count)]  = lat_vel;
            count_nx            = count + CW'(1);
        end else if (lat_on || found) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if ((IW'(i) >= rm_idx) && (IW'(i) < last_idx)) begin
                    note_nx[IW'(i)] = stk_note[IW'(i + 1)];
                    vel_nx[IW'(i)]  = stk_vel[IW'(i + 1)];
                end
            end
            if (lat_on) begin
                note_nx[last_idx] = lat_note;
                vel_nx[last_idx]  = lat_vel;
            end else begin
                count_nx = count - CW'(1);
            end
        end
        top_idx = IW'(count_nx - CW'(1));
    end

    // Commit the stack and registered outputs; pitch holds when the stack empties
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count       <= '0;
            o_note      <= '0;
            o_velocity  <= '0;
            o_retrigger <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_note[IW'(i)] <= '0;
                stk_vel[IW'(i)]  <= '0;
            end
        end else begin
            o_retrigger <= 1'b0;
            if ((state == ST_IDLE) && xfer && msg_anf) begin
                count <= '0;
            end
            if (state == ST_UPDATE) begin
                stk_note    <= note_nx;
                stk_vel     <= vel_nx;
                count       <= count_nx;
                o_retrigger <= lat_on;
                if (count_nx != '0) begin
                    o_note     <= note_nx[top_idx];
                    o_velocity <= vel_nx[top_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_note_tracker.sv
// Directed bench for mod_note_tracker: table of messages with hand-computed
// outputs and busy lengths, plus eviction and mid-search reset sequences.
module tb_mod_note_tracker;

    logic        i_clk;
    logic        i_rst;
    logic [23:0] i_msg;
    logic        i_msg_valid;
    logic        o_msg_ready;
    logic [6:0]  o_note;
    logic [6:0]  o_velocity;
    logic        o_gate;
    logic        o_retrigger;
    logic [3:0]  o_count;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [23:0] msg;
        int          exp_note;
        int          exp_vel;
        int          exp_gate;
        int          exp_count;
        int          exp_rt;
        int          exp_busy;
    } vec_t;

    vec_t vecs[16];

    mod_note_tracker #(
        .DEPTH   (8),
        .CHANNEL (0),
        .OMNI    (1'b0)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_msg       (i_msg),
        .i_msg_valid (i_msg_valid),
        .o_msg_ready (o_msg_ready),
        .o_note      (o_note),
        .o_velocity  (o_velocity),
        .o_gate      (o_gate),
        .o_retrigger (o_retrigger),
        .o_count     (o_count)
    );

    // Free-running clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hard stop in case something stalls outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input string name, input logic [23:0] msg,
                                   input int n, input int vel, input int g,
                                   input int c, input int rt, input int busy);
        vec_t v;
        v.name      = name;
        v.msg       = msg;
        v.exp_note  = n;
        v.exp_vel   = vel;
        v.exp_gate  = g;
        v.exp_count = c;
        v.exp_rt    = rt;
        v.exp_busy  = busy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ready"}, int'(o_msg_ready), 1);
        checkOutput({tag, " note"},  int'(o_note),      0);
        checkOutput({tag, " vel"},   int'(o_velocity),  0);
        checkOutput({tag, " gate"},  int'(o_gate),      0);
        checkOutput({tag, " rt"},    int'(o_retrigger), 0);
        checkOutput({tag, " count"}, int'(o_count),     0);
    endtask

    // Send one message, count busy cycles and retrigger pulses, check outputs
    task automatic applyStimulus(input vec_t v);
        int  busy;
        int  rt;
        bit  done;
        @(negedge i_clk);
        i_msg       = v.msg;
        i_msg_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_msg_valid = 1'b0;
        i_msg       = 24'h0;
        busy = 0;
        rt   = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge i_clk);
            rt += int'(o_retrigger);
            if (o_msg_ready) done = 1'b1;
            else busy++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: ready still 0 after 40 cycles, required 1", v.name);
        end
        checkOutput({v.name, " busy"},  busy,              v.exp_busy);
        checkOutput({v.name, " note"},  int'(o_note),      v.exp_note);
        checkOutput({v.name, " vel"},   int'(o_velocity),  v.exp_vel);
        checkOutput({v.name, " gate"},  int'(o_gate),      v.exp_gate);
        checkOutput({v.name, " count"}, int'(o_count),     v.exp_count);
        @(negedge i_clk);
        rt += int'(o_retrigger);
        checkOutput({v.name, " rtpulses"}, rt, v.exp_rt);
    endtask

    initial begin
        vec_t v;
        checks      = 0;
        errors      = 0;
        i_rst       = 1'b1;
        i_msg       = 24'h0;
        i_msg_valid = 1'b0;

        //               name       msg         note vel gate cnt rt busy
        vecs[0]  = mkVec("on60",    24'h903C64, 60, 100, 1, 1, 1, 2);
        vecs[1]  = mkVec("on64",    24'h904050, 64,  80, 1, 2, 1, 2);
        vecs[2]  = mkVec("on67",    24'h904346, 67,  70, 1, 3, 1, 3);
        vecs[3]  = mkVec("off67",   24'h804300, 64,  80, 1, 2, 0, 4);
        vecs[4]  = mkVec("off64",   24'h804040, 60, 100, 1, 1, 0, 3);
        vecs[5]  = mkVec("off60v0", 24'h903C00, 60, 100, 0, 0, 0, 2);
        vecs[6]  = mkVec("offEmpty",24'h803C40, 60, 100, 0, 0, 0, 2);
        vecs[7]  = mkVec("rs60",    24'h903C64, 60, 100, 1, 1, 1, 2);
        vecs[8]  = mkVec("rs64",    24'h904050, 64,  80, 1, 2, 1, 2);
        vecs[9]  = mkVec("restrike",24'h903C14, 60,  20, 1, 2, 1, 2);
        vecs[10] = mkVec("rsOff60", 24'h803C00, 64,  80, 1, 1, 0, 3);
        vecs[11] = mkVec("wrongCh", 24'h913C64, 64,  80, 1, 1, 0, 0);
        vecs[12] = mkVec("bend",    24'hE00040, 64,  80, 1, 1, 0, 0);
        vecs[13] = mkVec("f60",     24'h903C64, 60, 100, 1, 2, 1, 2);
        vecs[14] = mkVec("bit7",    24'h90C3C6, 67,  70, 1, 3, 1, 3);
        vecs[15] = mkVec("allOff",  24'hB07B00, 67,  70, 0, 0, 0, 0);

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        checkResetValues("reset");

        for (int k = 0; k < 16; k++) begin
            applyStimulus(vecs[k]);
        end

        // Nine presses into an eight-deep stack evict the oldest note
        for (int i = 0; i < 9; i++) begin
            v = mkVec($sformatf("push%0d", 40 + i), {8'h90, 8'(40 + i), 8'(10 + i)},
                      40 + i, 10 + i, 1, (i < 8) ? i + 1 : 8, 1, ((i < 1) ? 1 : i) + 1);
            applyStimulus(v);
        end
        for (int j = 0; j < 8; j++) begin
            v = mkVec($sformatf("rel%0d", 41 + j), {8'h80, 8'(41 + j), 8'h00},
                      48, 18, (j < 7) ? 1 : 0, 7 - j, 0, 2);
            applyStimulus(v);
        end
        applyStimulus(mkVec("rel40", 24'h802800, 48, 18, 0, 0, 0, 2));

        // Reset in the middle of a search must abort the message cleanly
        applyStimulus(mkVec("pre50", 24'h90321E, 50, 30, 1, 1, 1, 2));
        applyStimulus(mkVec("pre52", 24'h90341F, 52, 31, 1, 2, 1, 2));
        @(negedge i_clk);
        i_msg       = 24'h903764;
        i_msg_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_msg_valid = 1'b0;
        i_msg       = 24'h0;
        @(negedge i_clk);
        checkOutput("midsearch ready", int'(o_msg_ready), 0);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        checkResetValues("rstA");
        @(negedge i_clk);
        checkResetValues("rstB");
        applyStimulus(mkVec("postRst", 24'h903C64, 60, 100, 1, 1, 1, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
